// File: rtl/mau_seq_core.sv
// mau_seq_core: sequenced matrix algebra unit.
//   NUM_BANKS banks each hold one MATRIX_DIM x MATRIX_DIM matrix of unsigned
//   ELEM_W-bit elements. An instruction FSM streams a bank in from the host
//   (LOAD), out to the host (STORE, ready/valid), or runs one element per
//   cycle of ADD/SUB/MUL/SHL/COPY between banks (EXEC), optionally saturating.
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   host_instruction  {opcode[7:5], sat[4], dst/A[3:2], B[1:0]}, with instr_valid
//   data_in/valid     LOAD element stream
//   data_out/out_valid/out_ready  STORE element stream
//   busy_flag         instruction in progress (registered)
//   error             one-cycle pulse after an instruction naming a missing bank

// Element-wise arithmetic for one lane.
module mau_elem_alu #(
  parameter int ELEM_W = 8
) (
  input  logic [2:0]        op,
  input  logic              sat,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ELEM_W-1:0] y
);
  localparam int PW   = 2*ELEM_W;
  localparam int SH_W = (ELEM_W > 1) ? $clog2(ELEM_W) : 1;
  localparam logic [ELEM_W-1:0] ONES = {ELEM_W{1'b1}};

  logic [ELEM_W:0] sum;
  logic [PW-1:0]   prod;
  logic [PW-1:0]   shf;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign prod = PW'(a) * PW'(b);
  // Shift in a double-width field so shifted-out ones stay visible for saturation.
  assign shf  = PW'(a) << b[SH_W-1:0];

  always_comb begin
    y = b;
    case (op)
      3'b011: y = (sat && sum[ELEM_W]) ? ONES : sum[ELEM_W-1:0];
      3'b100: y = (sat && (a < b)) ? '0 : a - b;
      3'b101: y = (sat && |prod[PW-1:ELEM_W]) ? ONES : prod[ELEM_W-1:0];
      3'b110: y = (sat && |shf[PW-1:ELEM_W]) ? ONES : shf[ELEM_W-1:0];
      default: y = b;  // COPY
    endcase
  end
endmodule

module mau_seq_core #(
  parameter int MATRIX_DIM = 8,
  parameter int ELEM_W     = 8,
  parameter int NUM_BANKS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        host_instruction,
  input  logic              instr_valid,
  input  logic [ELEM_W-1:0] data_in,
  input  logic              data_valid,
  output logic [ELEM_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy_flag,
  output logic              error
);
  localparam int N_ELEM = MATRIX_DIM*MATRIX_DIM;
  localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int BK_W   = $clog2(NUM_BANKS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ELEM-1);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_EXEC} state_t;

  state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [2:0]       op_q;
  logic             sat_q;
  logic [BK_W-1:0]  dst_q, b_q;
  logic             busy_q, err_q, err_n, cap, wr_en;
  logic [ELEM_W-1:0] wr_data, a_val, b_val, alu_y;
  logic [NUM_BANKS-1:0][N_ELEM-1:0][ELEM_W-1:0] mem;

  // Instruction decode
  logic [2:0] op_in;
  logic [1:0] dst_in, b_in;
  logic       dst_bad, b_bad, bad;

  assign op_in   = host_instruction[7:5];
  assign dst_in  = host_instruction[3:2];
  assign b_in    = host_instruction[1:0];
  assign dst_bad = {1'b0, dst_in} >= 3'(NUM_BANKS);
  assign b_bad   = {1'b0, b_in}   >= 3'(NUM_BANKS);
  // LOAD/STORE use only the dst field.
  assign bad     = dst_bad || (!(op_in == OP_LOAD || op_in == OP_STORE) && b_bad);

  // Operands are read before this cycle's write, so dst aliasing A or B is safe.
  assign a_val = mem[dst_q][idx];
  assign b_val = mem[b_q][idx];

  mau_elem_alu #(.ELEM_W(ELEM_W)) u_alu (
    .op(op_q), .sat(sat_q), .a(a_val), .b(b_val), .y(alu_y)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    wr_en   = 1'b0;
    wr_data = alu_y;
    cap     = 1'b0;
    err_n   = 1'b0;
    case (state)
      S_IDLE:
        if (instr_valid && op_in != OP_NOP) begin
          if (bad) err_n = 1'b1;
          else begin
            cap = 1'b1;
            case (op_in)
              OP_LOAD:  state_n = S_LOAD;
              OP_STORE: state_n = S_STORE;
              default:  state_n = S_EXEC;
            endcase
          end
        end
      S_LOAD:
        if (data_valid) begin
          wr_en   = 1'b1;
          wr_data = data_in;
          idx_n   = idx + 1'b1;
          if (idx == LAST) begin
            idx_n   = '0;
            state_n = S_IDLE;
          end
        end
      S_STORE:
        if (out_ready) begin
          idx_n = idx + 1'b1;
          if (idx == LAST) begin
            idx_n   = '0;
            state_n = S_IDLE;
          end
        end
      S_EXEC: begin
        wr_en = 1'b1;
        idx_n = idx + 1'b1;
        if (idx == LAST) begin
          idx_n   = '0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      op_q   <= '0;
      sat_q  <= 1'b0;
      dst_q  <= '0;
      b_q    <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      mem    <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      busy_q <= (state_n != S_IDLE);
      err_q  <= err_n;
      if (cap) begin
        op_q  <= op_in;
        sat_q <= host_instruction[4];
        dst_q <= dst_in[BK_W-1:0];
        b_q   <= b_in[BK_W-1:0];
      end
      if (wr_en) mem[dst_q][idx] <= wr_data;
    end
  end

  assign busy_flag = busy_q;
  assign error     = err_q;
  assign out_valid = (state == S_STORE);
  assign data_out  = (state == S_STORE) ? mem[dst_q][idx] : '0;
endmodule

// File: tb/tb_mau_seq_core.sv
// Bench for mau_seq_core: a 4-bank and a 2-bank instance share the host
// inputs; `sel` routes instr_valid and the observed outputs to one of them.
// Bank contents are tracked in a plain array model and every STORE is
// compared element by element against it.
module tb_mau_seq_core;
  localparam int N    = 64;
  localparam int EW   = 8;
  localparam int MAXV = 255;

  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] host_instruction = '0;
  logic instr_valid = 1'b0, data_valid = 1'b0, out_ready = 1'b0, sel = 1'b0;
  logic [7:0] data_in = '0;

  logic [7:0] dout0, dout1, data_out;
  logic ov0, ov1, bz0, bz1, er0, er1, iv0, iv1;
  logic out_valid, busy_flag, error;

  always #5 clk = ~clk;

  assign iv0       = instr_valid & ~sel;
  assign iv1       = instr_valid & sel;
  assign data_out  = sel ? dout1 : dout0;
  assign out_valid = sel ? ov1 : ov0;
  assign busy_flag = sel ? bz1 : bz0;
  assign error     = sel ? er1 : er0;

  mau_seq_core #(.MATRIX_DIM(8), .ELEM_W(8), .NUM_BANKS(4)) u_dut (
    .clk(clk), .reset(reset), .host_instruction(host_instruction),
    .instr_valid(iv0), .data_in(data_in), .data_valid(data_valid),
    .data_out(dout0), .out_valid(ov0), .out_ready(out_ready),
    .busy_flag(bz0), .error(er0)
  );

  mau_seq_core #(.MATRIX_DIM(8), .ELEM_W(8), .NUM_BANKS(2)) u_dut2 (
    .clk(clk), .reset(reset), .host_instruction(host_instruction),
    .instr_valid(iv1), .data_in(data_in), .data_valid(data_valid),
    .data_out(dout1), .out_valid(ov1), .out_ready(out_ready),
    .busy_flag(bz1), .error(er1)
  );

  int unsigned mdl [2][4][N];
  int unsigned ld_vals [N];
  int checks = 0, passed = 0;

  function automatic int unsigned ref_op(input int op, input bit sat,
                                         input int unsigned a, input int unsigned b);
    int unsigned r;
    case (op)
      3: begin r = a + b; if (r > MAXV) r = sat ? MAXV : r - (MAXV + 1); end
      4: r = (a >= b) ? a - b : (sat ? 0 : a + (MAXV + 1) - b);
      5: begin r = a * b; if (r > MAXV) r = sat ? MAXV : r % (MAXV + 1); end
      6: begin r = a << (b % EW); if (r > MAXV) r = sat ? MAXV : r % (MAXV + 1); end
      default: r = b;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int op, input bit sat, input int d, input int b);
    host_instruction = {op[2:0], sat, d[1:0], b[1:0]};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic fill_const(input int unsigned v);
    for (int k = 0; k < N; k++) ld_vals[k] = v;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N; k++) ld_vals[k] = $urandom_range(0, MAXV);
  endtask

  task automatic do_load(input int d, input bit gapped);
    int i = 0, cyc = 0;
    issue(1, 1'b0, d, 0);
    checks++; if (busy_flag !== 1'b1) $display("FAIL load_busy_rise: got %b want 1", busy_flag); else passed++;
    while (i < N && cyc < 4*N) begin
      data_valid = !(gapped && (cyc % 3 == 2));
      data_in = 8'(ld_vals[i]);
      tick();
      if (data_valid) i++;
      cyc++;
    end
    data_valid = 1'b0;
    checks++; if (i != N) $display("FAIL load_timeout: got %0d elems want %0d", i, N); else passed++;
    checks++; if (busy_flag !== 1'b0) $display("FAIL load_busy_fall: got %b want 0", busy_flag); else passed++;
    for (int k = 0; k < N; k++) mdl[sel][d][k] = ld_vals[k];
  endtask

  // mode 0: out_ready toggles 1/0, 1: random, 2: always ready
  task automatic do_store(input int d, input int mode);
    int i = 0, cyc = 0;
    issue(2, 1'b0, d, 0);
    while (i < N && cyc < 8*N) begin
      checks++;
      if (out_valid !== 1'b1 || data_out !== 8'(mdl[sel][d][i]))
        $display("FAIL store_b%0d_e%0d: got valid=%b data=%0d want valid=1 data=%0d",
                 d, i, out_valid, data_out, mdl[sel][d][i]);
      else passed++;
      out_ready = (mode == 0) ? (cyc % 2 == 0) : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (out_ready) i++;
      cyc++;
    end
    out_ready = 1'b0;
    checks++; if (i != N) $display("FAIL store_timeout: got %0d elems want %0d", i, N); else passed++;
    checks++;
    if (out_valid !== 1'b0 || busy_flag !== 1'b0)
      $display("FAIL store_end: got valid=%b busy=%b want 0/0", out_valid, busy_flag);
    else passed++;
  endtask

  task automatic do_exec(input int op, input bit sat, input int d, input int b);
    int cnt = 0;
    int unsigned exp_v [N];
    for (int k = 0; k < N; k++) exp_v[k] = ref_op(op, sat, mdl[sel][d][k], mdl[sel][b][k]);
    issue(op, sat, d, b);
    while (busy_flag === 1'b1 && cnt < 4*N) begin cnt++; tick(); end
    checks++; if (cnt != N) $display("FAIL exec_busy_cycles op%0d: got %0d want %0d", op, cnt, N); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL exec_error op%0d: got %b want 0", op, error); else passed++;
    for (int k = 0; k < N; k++) mdl[sel][d][k] = exp_v[k];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (busy_flag !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_flag); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else passed++;
    checks++; if (data_out !== 8'd0) $display("FAIL reset_data_out: got %0d want 0", data_out); else passed++;
    reset = 1'b0;
    for (int s = 0; s < 2; s++) for (int b = 0; b < 4; b++) for (int k = 0; k < N; k++) mdl[s][b][k] = 0;
    tick();
  endtask

  task automatic test_load_store();
    for (int k = 0; k < N; k++) ld_vals[k] = k;
    do_load(0, 1'b1);
    do_store(0, 0);
  endtask

  task automatic test_add();
    fill_const(200); do_load(0, 1'b0);
    fill_const(100); do_load(1, 1'b0);
    do_exec(3, 1'b0, 0, 1); do_store(0, 2);
    fill_const(200); do_load(0, 1'b0);
    do_exec(3, 1'b1, 0, 1); do_store(0, 2);
  endtask

  task automatic test_sub_mul();
    fill_const(10); do_load(2, 1'b0);
    fill_const(20); do_load(3, 1'b0);
    do_exec(4, 1'b1, 2, 3); do_store(2, 2);
    do_exec(4, 1'b0, 3, 2); do_store(3, 2);
    do_exec(5, 1'b0, 3, 3); do_store(3, 2);
    fill_const(20); do_load(3, 1'b0);
    do_exec(5, 1'b1, 3, 3); do_store(3, 2);
  endtask

  task automatic test_shl_copy();
    fill_const(8'h81); do_load(0, 1'b0);
    fill_const(1);     do_load(1, 1'b0);
    do_exec(6, 1'b0, 0, 1); do_store(0, 2);
    fill_const(8'h81); do_load(0, 1'b0);
    do_exec(6, 1'b1, 0, 1); do_store(0, 2);
    fill_rand(); do_load(0, 1'b0);
    do_exec(7, 1'b0, 1, 0); do_store(1, 1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int op, d, b;
      op = $urandom_range(3, 7);
      d = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      fill_rand(); do_load(d, 1'b1);
      if (b != d) begin fill_rand(); do_load(b, 1'b0); end
      do_exec(op, 1'($urandom_range(0, 1)), d, b);
      do_store(d, 1);
    end
  endtask

  task automatic test_busy_ignore();
    int cnt = 0;
    bit err_seen = 1'b0;
    int unsigned exp_v [N];
    fill_rand(); do_load(0, 1'b0);
    fill_rand(); do_load(1, 1'b0);
    fill_rand(); do_load(2, 1'b0);
    for (int k = 0; k < N; k++) exp_v[k] = ref_op(3, 1'b0, mdl[0][0][k], mdl[0][1][k]);
    issue(3, 1'b0, 0, 1);
    // A LOAD to bank 2 with live data is held through every EXEC cycle, including the last.
    host_instruction = {3'd1, 1'b0, 2'd2, 2'd0};
    instr_valid = 1'b1;
    data_valid = 1'b1;
    data_in = 8'hA5;
    while (busy_flag === 1'b1 && cnt < 4*N) begin
      if (error !== 1'b0) err_seen = 1'b1;
      cnt++; tick();
    end
    instr_valid = 1'b0;
    data_valid = 1'b0;
    checks++; if (cnt != N) $display("FAIL busy_ignore_cycles: got %0d want %0d", cnt, N); else passed++;
    checks++; if (err_seen) $display("FAIL busy_ignore_error: got 1 want 0"); else passed++;
    tick();
    checks++; if (busy_flag !== 1'b0) $display("FAIL busy_ignore_accepted: got busy=%b want 0", busy_flag); else passed++;
    for (int k = 0; k < N; k++) mdl[0][0][k] = exp_v[k];
    do_store(0, 2);
    do_store(2, 2);
  endtask

  task automatic test_bad_bank();
    int bop [5] = '{3, 4, 7, 1, 2};
    int bd  [5] = '{3, 0, 1, 2, 3};
    int bb  [5] = '{1, 2, 3, 0, 0};
    sel = 1'b1;
    fill_rand(); do_load(0, 1'b0);
    for (int t = 0; t < 5; t++) begin
      issue(bop[t], 1'b0, bd[t], bb[t]);
      checks++;
      if (error !== 1'b1 || busy_flag !== 1'b0)
        $display("FAIL bad_bank_pulse%0d: got err=%b busy=%b want 1/0", t, error, busy_flag);
      else passed++;
      tick();
      checks++;
      if (error !== 1'b0 || busy_flag !== 1'b0)
        $display("FAIL bad_bank_after%0d: got err=%b busy=%b want 0/0", t, error, busy_flag);
      else passed++;
    end
    issue(0, 1'b1, 3, 3);
    checks++;
    if (error !== 1'b0 || busy_flag !== 1'b0)
      $display("FAIL bad_bank_nop: got err=%b busy=%b want 0/0", error, busy_flag);
    else passed++;
    do_store(0, 1);
    do_exec(3, 1'b0, 1, 0);
    do_store(1, 2);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    fill_rand();
    issue(1, 1'b0, 2, 0);
    for (int i = 0; i < 30; i++) begin
      data_valid = 1'b1; data_in = 8'(ld_vals[i]); tick();
    end
    reset = 1'b1;
    data_in = 8'(ld_vals[30]);
    tick();
    reset = 1'b0;
    data_valid = 1'b0;
    checks++;
    if (busy_flag !== 1'b0 || out_valid !== 1'b0 || error !== 1'b0)
      $display("FAIL midload_reset: got busy=%b valid=%b err=%b want 0/0/0", busy_flag, out_valid, error);
    else passed++;
    for (int s = 0; s < 2; s++) for (int b = 0; b < 4; b++) for (int k = 0; k < N; k++) mdl[s][b][k] = 0;
    for (int b = 0; b < 4; b++) do_store(b, 2);
    fill_rand(); do_load(2, 1'b1);
    do_store(2, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_load_store();
    test_add();
    test_sub_mul();
    test_shl_copy();
    test_random();
    test_busy_ignore();
    test_bad_bank();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
